// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with modulus, enable, clear, load, terminal count and wrap pulses.
// Build option: define UP_DOWN_COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module up_down_counter_param #(
  parameter int unsigned      WIDTH   = 8,
  parameter longint unsigned  MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count == MAX_W);
  assign at_zero = (count == ZERO_W);

  // Terminal count warns of a wrap on the next enabled edge; sclr/load are left to the consumer.
  assign tc = en & (mode ? at_max : at_zero);

  // Next-state selection, priority sclr > load > en; bounds compared explicitly for any modulus.
  always_comb begin
    count_nxt = count;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (sclr) begin
      count_nxt = ZERO_W;
    end else if (load) begin
      count_nxt = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (en) begin
      if (mode) begin
        if (at_max) begin
          ovf_nxt = 1'b1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
          count_nxt = MAX_W;
`else
          count_nxt = ZERO_W;
`endif
        end else begin
          count_nxt = count + ONE_W;
        end
      end else begin
        if (at_zero) begin
          unf_nxt = 1'b1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
          count_nxt = ZERO_W;
`else
          count_nxt = MAX_W;
`endif
        end else begin
          count_nxt = count - ONE_W;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= ZERO_W;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_up_down_counter_param.sv
// Directed bench for up_down_counter_param as a decade counter (WIDTH=4, MAX_VAL=9).
module tb_up_down_counter_param;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             mode;
  logic             sclr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             unf;

  int total;
  int bad;

  up_down_counter_param #(.WIDTH(WIDTH), .MAX_VAL(64'd9)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sclr(sclr), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0; en = 1'b0; mode = 1'b1; sclr = 1'b0; load = 1'b0; load_val = '0;
    tick(); tick();
    check("rst_count", int'(count), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_unf", int'(unf), 0);
    rst = 1'b1;

    // count up to 6, then reset asynchronously between edges
    en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_count", int'(count), 6);
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_ovf", int'(ovf), 0);
    check("async_rst_unf", int'(unf), 0);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("post_rst_count", int'(count), i);
    end

    // decade wrap up
    sclr = 1'b1;
    tick();
    check("sclr_count", int'(count), 0);
    sclr = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("up_count", int'(count), i);
      check("up_ovf", int'(ovf), 0);
      check("up_tc", int'(tc), (i == 9) ? 1 : 0);
    end
    tick();
    check("wrap_up_count", int'(count), 0);
    check("wrap_up_ovf", int'(ovf), 1);
    check("wrap_up_tc", int'(tc), 0);
    tick();
    check("after_wrap_count", int'(count), 1);
    check("after_wrap_ovf", int'(ovf), 0);

    // wrap down: load beats enable
    load = 1'b1; load_val = 4'd0;
    tick();
    check("load0_count", int'(count), 0);
    load = 1'b0; mode = 1'b0;
    #1;
    check("down_tc_at0", int'(tc), 1);
    tick();
    check("wrap_dn_count", int'(count), 9);
    check("wrap_dn_unf", int'(unf), 1);
    check("wrap_dn_ovf", int'(ovf), 0);
    for (int i = 8; i >= 0; i--) begin
      tick();
      check("dn_count", int'(count), i);
      check("dn_unf", int'(unf), 0);
      check("dn_tc", int'(tc), (i == 0) ? 1 : 0);
    end

    // priority and clamp
    sclr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1;
    tick();
    check("prio_sclr_count", int'(count), 0);
    sclr = 1'b0; load_val = 4'd15;
    tick();
    check("clamp_count", int'(count), 9);
    load = 1'b0; en = 1'b0; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_count", int'(count), 9);
      check("hold_tc", int'(tc), 0);
      check("hold_ovf", int'(ovf), 0);
    end

    // direction flip at the upper boundary
    en = 1'b1; mode = 1'b1;
    #1;
    check("flip_tc_up", int'(tc), 1);
    mode = 1'b0;
    #1;
    check("flip_tc_dn", int'(tc), 0);
    tick();
    check("flip_count", int'(count), 8);
    check("flip_ovf", int'(ovf), 0);
    check("flip_unf", int'(unf), 0);

    // behaviour past the upper and lower bounds
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; mode = 1'b1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_up_count", int'(count), 9);
      check("sat_up_ovf", int'(ovf), 1);
    end
    mode = 1'b0;
    tick();
    check("sat_rel_count", int'(count), 8);
    check("sat_rel_ovf", int'(ovf), 0);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    tick();
    check("sat_dn_count", int'(count), 0);
    check("sat_dn_unf", int'(unf), 1);
`else
    tick();
    check("wrap9_count", int'(count), 0);
    check("wrap9_ovf", int'(ovf), 1);
    check("wrap9_unf", int'(unf), 0);
    mode = 1'b0;
    tick();
    check("wrap0_count", int'(count), 9);
    check("wrap0_unf", int'(unf), 1);
    check("wrap0_ovf", int'(ovf), 0);
`endif
    en = 1'b0;
    tick();
    check("idle_ovf", int'(ovf), 0);
    check("idle_unf", int'(unf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/up_down_counter_param.md
Name: up_down_counter_param

Overview:
- Parametrised successor to the team's 4-bit up/down counter.
- Adds configurable width and modulus, count enable, synchronous clear, parallel load, a terminal-count flag and registered overflow/underflow pulses.
- Used as a general event, timer or decade counter in datapath and control blocks.
- One clock domain. Reset is asynchronous and active-low.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1, highest count value (modulus = MAX_VAL+1); legal range 1..2**WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low; 0 forces reset state immediately.
- en  input  1  count enable; counts one step per cycle when 1.
- mode  input  1  direction; 1 = up, 0 = down.
- sclr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- count  output  WIDTH  current count; registered.
- tc  output  1  terminal count; combinational.
- ovf  output  1  overflow pulse; registered, one cycle wide.
- unf  output  1  underflow pulse; registered, one cycle wide.

Behaviour:
- Reset (rst=0, asynchronous): count=0, ovf=0, unf=0, applied without waiting for a clock edge.
- Release: rst deasserts and the block operates from the next rising clk edge.
- Reset mid-count discards all state; nothing is retained.
- Priority at each rising edge: sclr > load > en.
- sclr=1: count<=0, ovf<=0, unf<=0.
- load=1 (sclr=0):
  - count<=load_val if load_val<=MAX_VAL, otherwise count<=MAX_VAL (clamped).
  - ovf<=0, unf<=0.
- en=1, mode=1:
  - count<count MAX_VAL: count<=count+1.
  - count==MAX_VAL: count<=0 and ovf<=1 for exactly one cycle.
- en=1, mode=0:
  - count>0: count<=count-1.
  - count==0: count<=MAX_VAL and unf<=1 for exactly one cycle.
- en=0 (no sclr or load): count holds; ovf<=0, unf<=0.
- Latency: count, ovf and unf are visible one cycle after the qualifying edge. No combinational path from inputs to count, ovf or unf.
- tc = en & (mode ? count==MAX_VAL : count==0).
  - Asserted in the cycle before a wrap.
  - Suppressed when en=0.
  - Not gated by sclr or load; the consumer qualifies it if needed.
- Arithmetic: compare against MAX_VAL, never rely on natural WIDTH rollover. Correct for non-power-of-two moduli.
- mode may change on any cycle; it takes effect on that edge.
- ovf and unf are never asserted together.
- count never exceeds MAX_VAL under any input sequence.

Optional Feature:
- Macro: UP_DOWN_COUNTER_SATURATE_EN.
- Defined:
  - Up at MAX_VAL holds MAX_VAL; down at 0 holds 0.
  - ovf/unf still pulse one cycle on each attempted step past the bound. They repeat every enabled cycle while the counter is held at the bound.
  - tc behaviour is unchanged.
- Undefined (default): wrap-around behaviour as above.
- No port or parameter difference between the two builds.

Test Plan:
- Reset: WIDTH=4, MAX_VAL=9, count mid-run at 6. Drive rst=0 between clock edges -> count=0, ovf=unf=0 immediately. Release rst, en=1, mode=1 -> 1,2,3 on successive edges.
- Decade wrap up: en=1, mode=1 from 0 -> 0..9 then 0. tc=1 while count=9. ovf=1 only in the cycle count=0 after the wrap.
- Wrap down: load 0, then en=1, mode=0 -> 9,8,...; unf=1 only in the first cycle count=9. tc=1 while count=0.
- Priority and clamp:
  - sclr=1, load=1, load_val=5, en=1 -> count=0.
  - Next cycle load=1, load_val=15 -> count=9 (clamped).
  - en=0 for 3 cycles -> count holds 9, tc=0.
- Direction flip at boundary: count=9, mode=1, en=1 (tc=1); flip mode=0 on that edge -> count=8, no ovf, no unf.
- Saturate build (macro defined): count=9, en=1, mode=1 for 3 cycles -> count stays 9, ovf=1 each of the 3 cycles. Then mode=0 -> count=8, ovf=0.
